// File: rtl/aes_inv_keysched128.sv
// Purpose: inverse AES-128 key schedule; loads the round-10 key and emits round keys 10..0.
// Latency: round-10 key valid the cycle after start; then one key per transfer, done 1 cycle after round 0.
// Backpressure: key_ready low stalls the sequence; round_key/key_round hold until the transfer completes.

// Byte rotate left: [a0,a1,a2,a3] -> [a1,a2,a3,a0], byte 0 in [31:24].
module rotword (
    input  logic [31:0] word,
    output logic [31:0] result
);
    assign result = {word[23:0], word[31:24]};
endmodule

// AES S-box applied independently to each byte of a word.
module subword (
    input  logic [31:0] word,
    output logic [31:0] result
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    assign result = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};
endmodule

module aes_inv_keysched128 #(
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   key_round,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

    state_t      state, state_nxt;
    logic        xfer;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot_p3, sub_p3, rcon;
    logic [127:0] prev_key;

    assign xfer = key_valid && key_ready;

    // State register; reset always wins over a coincident start.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: leave EMIT only when the round-0 key is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_EMIT;
            S_EMIT:  if (xfer && key_round == 4'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decode directly from the state.
    always_comb begin
        key_valid = (state == S_EMIT);
        busy      = (state == S_EMIT);
        done      = (state == S_DONE);
    end

    // Inverse expansion: undo the chained XORs, then strip the g() term from word 0.
    assign n0 = round_key[127:96];
    assign n1 = round_key[95:64];
    assign n2 = round_key[63:32];
    assign n3 = round_key[31:0];
    assign p3 = n3 ^ n2;
    assign p2 = n2 ^ n1;
    assign p1 = n1 ^ n0;

    rotword u_rot (.word(p3),     .result(rot_p3));
    subword u_sub (.word(rot_p3), .result(sub_p3));

    // Round constant used when the current key (round key_round) was generated.
    always_comb begin
        rcon = 32'h0;
        case (key_round)
            4'd1:    rcon = 32'h0100_0000;
            4'd2:    rcon = 32'h0200_0000;
            4'd3:    rcon = 32'h0400_0000;
            4'd4:    rcon = 32'h0800_0000;
            4'd5:    rcon = 32'h1000_0000;
            4'd6:    rcon = 32'h2000_0000;
            4'd7:    rcon = 32'h4000_0000;
            4'd8:    rcon = 32'h8000_0000;
            4'd9:    rcon = 32'h1b00_0000;
            4'd10:   rcon = 32'h3600_0000;
            default: rcon = 32'h0;
        endcase
    end

    assign p0       = n0 ^ sub_p3 ^ rcon;
    assign prev_key = {p0, p1, p2, p3};

    // Key register: load on accepted start, step back one round per transfer, hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            round_key <= '0;
            key_round <= '0;
        end else if (state == S_IDLE && start) begin
            round_key <= last_key;
            key_round <= 4'(NROUNDS);
        end else if (state == S_EMIT && xfer && key_round != 4'd0) begin
            round_key <= prev_key;
            key_round <= key_round - 4'd1;
        end
    end
endmodule

// File: tb/tb_aes_inv_keysched128.sv
// Bench for the inverse AES-128 key schedule: FIPS-197 A.1 directed runs plus a forward-expansion scoreboard.
// Inputs change and outputs are sampled on the falling edge.
// Covers stalls, ignored start while busy, mid-sequence reset and random backpressure.
module tb_aes_inv_keysched128;
    logic         clk = 1'b0;
    logic         reset, start, key_ready;
    logic [127:0] last_key;
    logic         key_valid, busy, done;
    logic [127:0] round_key;
    logic [3:0]   key_round;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_keys [11];
    bit           pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    localparam logic [127:0] FIPS [11] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };

    localparam logic [7:0] RC [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

    localparam logic [7:0] SB [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    aes_inv_keysched128 #(.NROUNDS(10)) dut (
        .clk(clk), .reset(reset), .start(start), .last_key(last_key), .key_ready(key_ready),
        .key_valid(key_valid), .round_key(round_key), .key_round(key_round), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Forward key expansion from the cipher key, filling exp_keys[0..10].
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]} ^ {RC[i/4-1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called on a falling edge with the DUT idle; returns on the falling edge after the load.
    task automatic do_start(input logic [127:0] k);
        start = 1'b1; last_key = k;
        @(negedge clk);
        start = 1'b0; last_key = '0;
        chk("start_busy", busy, 1);
        chk("start_valid", key_valid, 1);
        chk("start_round", key_round, 10);
        chk("start_key", round_key, k);
    endtask

    // mode 0: ready=1, 1: fixed toggle pattern, 2: random ready.
    task automatic collect(input int mode, input int inject_at, input int abort_at);
        int r = 10;
        int cyc = 0;
        int pidx = 0;
        bit stalled = 1'b0;
        logic [127:0] held_key;
        logic [3:0]   held_rnd;
        while (r >= 0 && cyc < 400) begin
            cyc++;
            if (stalled) begin
                chk("stall_key", round_key, held_key);
                chk("stall_rnd", key_round, held_rnd);
            end
            chk("valid_hi", key_valid, 1);
            if (r == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            start = (r == inject_at);
            if (start) last_key = '0;
            case (mode)
                0:       key_ready = 1'b1;
                1:       key_ready = pat[pidx % 6];
                default: key_ready = 1'($urandom_range(0, 1));
            endcase
            pidx++;
            if (key_ready) begin
                chk($sformatf("round_idx%0d", r), key_round, r);
                chk($sformatf("round_key%0d", r), round_key, exp_keys[r]);
                r--;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_key = round_key;
                held_rnd = key_round;
            end
            @(negedge clk);
            start = 1'b0;
        end
        if (r >= 0) chk("timeout", 0, 1);
        chk("done_pulse", done, 1);
        chk("busy_lo", busy, 0);
        chk("valid_lo", key_valid, 0);
        @(negedge clk);
        chk("done_clr", done, 0);
        chk("busy_idle", busy, 0);
        chk("valid_idle", key_valid, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; key_ready = 1'b0; last_key = FIPS[10];
        repeat (2) @(negedge clk);
        chk("rst_valid", key_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_round", key_round, 0);
        chk("rst_key", round_key, 0);
        reset = 1'b0; start = 1'b0; last_key = '0;
        @(negedge clk);
        chk("idle_valid", key_valid, 0);

        for (int r = 0; r < 11; r++) exp_keys[r] = FIPS[r];

        // Full-rate run
        do_start(FIPS[10]);
        collect(0, -1, -1);
        // Toggling backpressure
        do_start(FIPS[10]);
        collect(1, -1, -1);
        // start while busy must not reload
        do_start(FIPS[10]);
        collect(0, 6, -1);
        // Reset in the middle, then a clean restart
        do_start(FIPS[10]);
        collect(0, -1, 4);
        chk("abort_valid", key_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_round", key_round, 0);
        chk("abort_key", round_key, 0);
        do_start(FIPS[10]);
        collect(0, -1, -1);

        // Random keys against the forward-expansion model
        for (int n = 0; n < 100; n++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            do_start(exp_keys[10]);
            collect(2, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
